// File: rtl/complex_addsub_vec_pipe.sv
// complex_addsub_vec_pipe: LANES-wide complex add/sub with conjugate modes,
// optional saturation and a ce-gated LAT-stage pipeline with overflow flags.
module complex_addsub_vec_pipe #(
  parameter int W     = 32,
  parameter int LANES = 1,
  parameter int LAT   = 2,
  parameter bit SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [2*W*LANES-1:0]   A,
  input  logic [2*W*LANES-1:0]   B,
  input  logic                   clr_ovf,
  output logic [2*W*LANES-1:0]   result,
  output logic                   finish,
  output logic [LANES-1:0]       ovf,
  output logic [LANES-1:0]       ovf_sticky,
  output logic                   busy
);

  localparam int DW = 2*W*LANES;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [DW-1:0]    w_res;
  logic [LANES-1:0] w_ovf;
  logic             w_sub_re;
  logic             w_sub_im;

  // conj(B) flips only the imaginary operation
  assign w_sub_re = op[0];
  assign w_sub_im = op[0] ^ op[1];

  function automatic logic [W-1:0] clip(input logic [W:0] s);
    if (SAT && (s[W] != s[W-1]))
      return s[W] ? MINV : MAXV;
    return s[W-1:0];
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0] w_ar, w_ai, w_br, w_bi;
    logic [W:0]   w_sr, w_si;
    assign w_ar = A[2*W*k+W +: W];
    assign w_ai = A[2*W*k   +: W];
    assign w_br = B[2*W*k+W +: W];
    assign w_bi = B[2*W*k   +: W];
    assign w_sr = w_sub_re
      ? {w_ar[W-1], w_ar} - {w_br[W-1], w_br}
      : {w_ar[W-1], w_ar} + {w_br[W-1], w_br};
    assign w_si = w_sub_im
      ? {w_ai[W-1], w_ai} - {w_bi[W-1], w_bi}
      : {w_ai[W-1], w_ai} + {w_bi[W-1], w_bi};
    assign w_res[2*W*k+W +: W] = clip(w_sr);
    assign w_res[2*W*k   +: W] = clip(w_si);
    assign w_ovf[k] = (w_sr[W] ^ w_sr[W-1]) | (w_si[W] ^ w_si[W-1]);
  end

  logic             w_v_out;
  logic [DW-1:0]    w_d_out;
  logic [LANES-1:0] w_o_out;
  logic             w_busy_int;

  if (LAT == 1) begin : g_lat1
    assign w_v_out    = start;
    assign w_d_out    = w_res;
    assign w_o_out    = w_ovf;
    assign w_busy_int = 1'b0;
  end else begin : g_latn
    logic [LAT-2:0]            r_v;
    logic [LAT-2:0][DW-1:0]    r_d;
    logic [LAT-2:0][LANES-1:0] r_o;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= '0;
        r_d <= '0;
        r_o <= '0;
      end else if (ce) begin
        r_v[0] <= start;
        r_d[0] <= w_res;
        r_o[0] <= w_ovf;
        for (int i = 1; i < LAT-1; i++) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
          r_o[i] <= r_o[i-1];
        end
      end
    end

    assign w_v_out    = r_v[LAT-2];
    assign w_d_out    = r_d[LAT-2];
    assign w_o_out    = r_o[LAT-2];
    assign w_busy_int = |r_v;
  end

  logic w_fin;
  assign w_fin = ce & w_v_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      ovf        <= '0;
      finish     <= 1'b0;
      ovf_sticky <= '0;
    end else begin
      finish <= w_fin;
      if (w_fin) begin
        result <= w_d_out;
        ovf    <= w_o_out;
      end
      // clear wins over history but not over the flags landing this edge
      if (clr_ovf)
        ovf_sticky <= w_fin ? w_o_out : '0;
      else if (w_fin)
        ovf_sticky <= ovf_sticky | w_o_out;
    end
  end

  assign busy = w_busy_int | finish;

endmodule
